demap_frame_ctrl: RTL and testbench

DEMAP_FRAME_CTRL -- requirements
Module: demap_frame_ctrl

---
 rtl/demap_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_demap_frame_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demap_frame_ctrl.sv
// Purpose : frame alignment for a 4-row x COLS line stream. Hunts for FAS,
//           confirms it over SYNC_CNT frames, then tags each byte with its
//           row/col and declares loss of frame after LOF_CNT missed FAS.
// Latency : every output is registered, 1 cycle from the input beat.
// Backpres: none. Beats with i_frame_data_valid=0 are gaps; the position
//           and the alignment state hold across gaps.
// Ports   : i_clk, i_rst_n (async, active-low); i_frame_data[7:0],
//           i_frame_data_valid, i_frame_data_fas in; o_frame_data[7:0],
//           o_frame_data_valid, o_frame_data_fas, o_row_cnt[1:0],
//           o_col_cnt[10:0], o_in_frame, o_lof out.
// Option  : define DEMAP_FRAME_CTRL_STATS_EN to add o_frame_cnt[15:0]
//           (wrapping count of locked frames) and o_miss_cnt[15:0]
//           (saturating count of FAS misses while locked).
module demap_frame_ctrl #(
  parameter int COLS     = 1041,
  parameter int SYNC_CNT = 2,
  parameter int LOF_CNT  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_frame_data,
  input  logic        i_frame_data_valid,
  input  logic        i_frame_data_fas,
  output logic [7:0]  o_frame_data,
  output logic        o_frame_data_valid,
  output logic        o_frame_data_fas,
  output logic [1:0]  o_row_cnt,
  output logic [10:0] o_col_cnt,
`ifdef DEMAP_FRAME_CTRL_STATS_EN
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_miss_cnt,
`endif
  output logic        o_in_frame,
  output logic        o_lof
);

  typedef enum logic [1:0] {HUNT = 2'd0, PRESYNC = 2'd1, SYNC = 2'd2} state_t;

  localparam logic [10:0] COL_LAST = 11'(COLS - 1);
  localparam logic [2:0]  SYNC_N   = 3'(SYNC_CNT);
  localparam logic [2:0]  LOF_N    = 3'(LOF_CNT);

  state_t      state_q, state_d;
  logic [2:0]  good_q, good_d;
  logic [2:0]  miss_q, miss_d;
  // Position the next valid beat will occupy.
  logic [1:0]  pos_row_q;
  logic [10:0] pos_col_q;

  logic        realign;
  logic        expected;
  logic [1:0]  beat_row;
  logic [10:0] beat_col;

  logic [7:0]  data_d;
  logic        vld_d, fas_d, in_frame_d, lof_d;
  logic [1:0]  row_d;
  logic [10:0] col_d;

  assign expected = i_frame_data_valid && (pos_row_q == 2'd0) && (pos_col_q == 11'd0);

  // A realigning FAS beat is itself (0,0); otherwise the beat takes the tracked position.
  assign beat_row = realign ? 2'd0  : pos_row_q;
  assign beat_col = realign ? 11'd0 : pos_col_q;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= HUNT;
      good_q  <= 3'd0;
      miss_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    realign = 1'b0;
    case (state_q)
      HUNT: begin
        if (i_frame_data_valid && i_frame_data_fas) begin
          state_d = PRESYNC;
          good_d  = 3'd0;
          realign = 1'b1;
        end
      end
      PRESYNC: begin
        if (expected) begin
          if (i_frame_data_fas) begin
            good_d = good_q + 3'd1;
            if (good_q + 3'd1 == SYNC_N) begin
              state_d = SYNC;
              miss_d  = 3'd0;
            end
          end else begin
            state_d = HUNT;
          end
        end else if (i_frame_data_valid && i_frame_data_fas) begin
          // FAS off the expected grid: restart confirmation from this beat.
          good_d  = 3'd0;
          realign = 1'b1;
        end
      end
      SYNC: begin
        // FAS away from (0,0) is ignored once locked.
        if (expected) begin
          if (i_frame_data_fas) begin
            miss_d = 3'd0;
          end else if (miss_q + 3'd1 == LOF_N) begin
            state_d = HUNT;
            miss_d  = 3'd0;
          end else begin
            miss_d = miss_q + 3'd1;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Output logic (D side of the output registers)
  always_comb begin
    data_d     = i_frame_data;
    vld_d      = i_frame_data_valid && (state_d == SYNC);
    fas_d      = vld_d && (beat_row == 2'd0) && (beat_col == 11'd0);
    in_frame_d = (state_d == SYNC);
    lof_d      = (state_q == SYNC) && (state_d == HUNT);
    row_d      = i_frame_data_valid ? beat_row : o_row_cnt;
    col_d      = i_frame_data_valid ? beat_col : o_col_cnt;
  end

  // Position tracker and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pos_row_q          <= 2'd0;
      pos_col_q          <= 11'd0;
      o_frame_data       <= 8'd0;
      o_frame_data_valid <= 1'b0;
      o_frame_data_fas   <= 1'b0;
      o_row_cnt          <= 2'd0;
      o_col_cnt          <= 11'd0;
      o_in_frame         <= 1'b0;
      o_lof              <= 1'b0;
    end else begin
      if (i_frame_data_valid) begin
        if (beat_col == COL_LAST) begin
          pos_col_q <= 11'd0;
          pos_row_q <= beat_row + 2'd1;
        end else begin
          pos_col_q <= beat_col + 11'd1;
          pos_row_q <= beat_row;
        end
      end
      o_frame_data       <= data_d;
      o_frame_data_valid <= vld_d;
      o_frame_data_fas   <= fas_d;
      o_row_cnt          <= row_d;
      o_col_cnt          <= col_d;
      o_in_frame         <= in_frame_d;
      o_lof              <= lof_d;
    end
  end

`ifdef DEMAP_FRAME_CTRL_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_cnt <= 16'd0;
      o_miss_cnt  <= 16'd0;
    end else if ((state_q == SYNC) && expected) begin
      if (i_frame_data_fas) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end else if (o_miss_cnt != 16'hFFFF) begin
        o_miss_cnt <= o_miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demap_frame_ctrl.sv
module tb_demap_frame_ctrl;

  localparam int COLS     = 41;
  localparam int SYNC_CNT = 2;
  localparam int LOF_CNT  = 3;
  localparam int FRAME    = 4 * COLS;

  localparam int M_HUNT = 0;
  localparam int M_PRE  = 1;
  localparam int M_SYNC = 2;

  logic        i_clk;
  logic        i_rst_n;
  logic [7:0]  i_frame_data;
  logic        i_frame_data_valid;
  logic        i_frame_data_fas;
  logic [7:0]  o_frame_data;
  logic        o_frame_data_valid;
  logic        o_frame_data_fas;
  logic [1:0]  o_row_cnt;
  logic [10:0] o_col_cnt;
  logic        o_in_frame;
  logic        o_lof;
`ifdef DEMAP_FRAME_CTRL_STATS_EN
  logic [15:0] o_frame_cnt;
  logic [15:0] o_miss_cnt;
`endif

  demap_frame_ctrl #(.COLS(COLS), .SYNC_CNT(SYNC_CNT), .LOF_CNT(LOF_CNT)) u_dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_frame_data       (i_frame_data),
    .i_frame_data_valid (i_frame_data_valid),
    .i_frame_data_fas   (i_frame_data_fas),
    .o_frame_data       (o_frame_data),
    .o_frame_data_valid (o_frame_data_valid),
    .o_frame_data_fas   (o_frame_data_fas),
    .o_row_cnt          (o_row_cnt),
    .o_col_cnt          (o_col_cnt),
`ifdef DEMAP_FRAME_CTRL_STATS_EN
    .o_frame_cnt        (o_frame_cnt),
    .o_miss_cnt         (o_miss_cnt),
`endif
    .o_in_frame         (o_in_frame),
    .o_lof              (o_lof)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_lof   = 0;

  // Reference model: position is a beat index within the 4*COLS frame.
  int          m_mode, m_idx, m_good, m_miss, m_frames, m_misses;
  logic [7:0]  exp_data;
  logic        exp_vld, exp_fas, exp_inf, exp_lof;
  logic [1:0]  exp_row;
  logic [10:0] exp_col;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] dut_vec();
    return {o_frame_data, o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt, o_in_frame, o_lof};
  endfunction

  function automatic logic [24:0] exp_vec();
    return {exp_data, exp_vld, exp_fas, exp_row, exp_col, exp_inf, exp_lof};
  endfunction

  task automatic check_stats(input string tag);
`ifdef DEMAP_FRAME_CTRL_STATS_EN
    check({tag, "_stats"}, {32'd0, o_frame_cnt, o_miss_cnt}, {32'd0, 16'(m_frames), 16'(m_misses)});
`else
    n_tests = n_tests + 0;
`endif
  endtask

  task automatic model_reset();
    m_mode = M_HUNT; m_idx = 0; m_good = 0; m_miss = 0; m_frames = 0; m_misses = 0;
    exp_data = 8'd0; exp_vld = 1'b0; exp_fas = 1'b0; exp_inf = 1'b0; exp_lof = 1'b0;
    exp_row = 2'd0; exp_col = 11'd0;
  endtask

  task automatic model_step(input logic v, input logic f, input logic [7:0] d);
    int idx;
    exp_data = d;
    exp_lof  = 1'b0;
    exp_vld  = 1'b0;
    exp_fas  = 1'b0;
    if (v) begin
      idx = m_idx;
      if (m_mode == M_HUNT) begin
        if (f) begin idx = 0; m_mode = M_PRE; m_good = 0; end
      end else if (m_mode == M_PRE) begin
        if (idx == 0) begin
          if (f) begin
            m_good++;
            if (m_good == SYNC_CNT) begin m_mode = M_SYNC; m_miss = 0; end
          end else begin
            m_mode = M_HUNT;
          end
        end else if (f) begin
          idx = 0; m_good = 0;
        end
      end else begin
        if (idx == 0) begin
          if (f) begin
            m_miss = 0;
            m_frames = (m_frames + 1) % 65536;
          end else begin
            m_miss++;
            if (m_misses < 65535) m_misses++;
            if (m_miss == LOF_CNT) begin m_mode = M_HUNT; m_miss = 0; exp_lof = 1'b1; end
          end
        end
      end
      exp_row = 2'(idx / COLS);
      exp_col = 11'(idx % COLS);
      exp_vld = (m_mode == M_SYNC);
      exp_fas = exp_vld && (idx == 0);
      m_idx   = (idx + 1) % FRAME;
    end
    exp_inf = (m_mode == M_SYNC);
  endtask

  task automatic beat(input logic v, input logic f);
    @(negedge i_clk);
    i_frame_data       = 8'($urandom);
    i_frame_data_valid = v;
    i_frame_data_fas   = f;
    model_step(v, f, i_frame_data);
    @(posedge i_clk);
    #1;
    check("beat", 64'(dut_vec()), 64'(exp_vec()));
    if (o_lof) n_lof++;
  endtask

  // One frame of FRAME valid beats; FAS on beat 0 if first_fas, plus beat false_at.
  task automatic send_frame(input bit first_fas, input int false_at, input int gap_every, input bit rnd_gaps);
    for (int k = 0; k < FRAME; k++) begin
      if (gap_every > 0 && k > 0 && (k % gap_every) == 0)
        repeat (5) beat(1'b0, 1'($urandom));
      else if (rnd_gaps && $urandom_range(0, 19) == 0)
        beat(1'b0, 1'($urandom));
      beat(1'b1, (k == 0) ? first_fas : (k == false_at));
    end
  endtask

  task automatic apply_async_reset();
    #2;
    i_rst_n = 1'b0;
    i_frame_data_valid = 1'b0;
    #1;
    model_reset();
    check("arst_outputs", 64'(dut_vec()), 64'd0);
    check_stats("arst");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    int l0;
    i_rst_n = 1'b0;
    i_frame_data = 8'd0;
    i_frame_data_valid = 1'b0;
    i_frame_data_fas = 1'b0;
    model_reset();
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs", 64'(dut_vec()), 64'd0);
    check_stats("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4) beat(1'b0, 1'($urandom));

    // Clean lock: third FAS enters SYNC.
    l0 = n_lof;
    send_frame(1'b1, -1, 0, 1'b0);
    send_frame(1'b1, -1, 0, 1'b0);
    check("prelock_in_frame", 64'(o_in_frame), 64'd0);
    beat(1'b1, 1'b1);
    check("lock_in_frame", 64'(o_in_frame), 64'd1);
    check("lock_first_pos", 64'({o_frame_data_valid, o_frame_data_fas, o_row_cnt, o_col_cnt}), 64'({1'b1, 1'b1, 2'd0, 11'd0}));
    for (int k = 1; k < FRAME; k++) beat(1'b1, 1'b0);
    check("lock_last_pos", 64'({o_row_cnt, o_col_cnt}), 64'({2'd3, 11'(COLS - 1)}));

    // Gaps of 5 idle cycles every 100 beats.
    send_frame(1'b1, -1, 100, 1'b0);
    send_frame(1'b1, -1, 100, 1'b0);
    check("gaps_in_frame", 64'(o_in_frame), 64'd1);
    check("gaps_no_lof", 64'(n_lof - l0), 64'd0);

    // Two misses then a hit keeps lock.
    send_frame(1'b0, -1, 0, 1'b0);
    send_frame(1'b0, -1, 0, 1'b0);
    send_frame(1'b1, -1, 0, 1'b0);
    check("miss2_in_frame", 64'(o_in_frame), 64'd1);
    check("miss2_no_lof", 64'(n_lof - l0), 64'd0);
    check_stats("miss2");

    // Three misses: loss of frame.
    send_frame(1'b0, -1, 0, 1'b0);
    send_frame(1'b0, -1, 0, 1'b0);
    beat(1'b1, 1'b0);
    check("lof_pulse", 64'({o_lof, o_in_frame, o_frame_data_valid}), 64'({1'b1, 1'b0, 1'b0}));
    beat(1'b1, 1'b0);
    check("lof_one_cycle", 64'(o_lof), 64'd0);
    for (int k = 2; k < FRAME; k++) beat(1'b1, 1'b0);
    check("lof_count", 64'(n_lof - l0), 64'd1);

    // False FAS in PRESYNC realigns the grid to that beat.
    send_frame(1'b1, 100, 0, 1'b0);
    send_frame(1'b0, 100, 0, 1'b0);
    send_frame(1'b0, 100, 0, 1'b0);
    check("presync_realign_lock", 64'(o_in_frame), 64'd1);

    // False FAS in SYNC is ignored (beat 0 is now off-grid).
    l0 = n_lof;
    send_frame(1'b1, 100, 0, 1'b0);
    send_frame(1'b1, 100, 0, 1'b1);
    check("sync_false_fas_lock", 64'(o_in_frame), 64'd1);
    check("sync_false_fas_no_lof", 64'(n_lof - l0), 64'd0);
    check_stats("sync");

    // Async reset mid-frame, then three FAS to relock.
    repeat (60) beat(1'b1, 1'b0);
    apply_async_reset();
    send_frame(1'b1, -1, 0, 1'b0);
    send_frame(1'b1, -1, 0, 1'b0);
    check("relock_not_yet", 64'(o_in_frame), 64'd0);
    send_frame(1'b1, -1, 0, 1'b0);
    check("relock_in_frame", 64'(o_in_frame), 64'd1);

    // Randomised frames: missing FAS, stray FAS and gaps.
    for (int n = 0; n < 25; n++) begin
      send_frame($urandom_range(0, 99) < 80, ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, FRAME - 1)) : -1,
                 0, 1'b1);
    end
    check_stats("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
